// File: rtl/fp_mac_pkg.sv
// Shared types and helpers for the two-requester floating-point MAC scheduler.
package fp_mac_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_MSB = 30;
    localparam int unsigned EXP_LSB = 23;
    localparam int unsigned MAN_MSB = 22;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // True for +0 and -0: exponent and mantissa both zero, sign ignored.
    function automatic logic is_fp_zero(input logic [FP_W-1:0] x);
        return (x[EXP_MSB:EXP_LSB] == '0) && (x[MAN_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the pointer side.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fp_mac_sched.sv
// Shares one FP MAC datapath between two requesters, one dot-product job at a time.
// Optional build macro FP_MAC_ZERO_SKIP_EN suppresses mac_en for pairs with a +/-0 operand.
module fp_mac_sched
    import fp_mac_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [LEN_W-1:0] len1_i,
    output logic [1:0]       gnt_o,
    input  logic [FP_W-1:0]  op0_a_i,
    input  logic [FP_W-1:0]  op0_b_i,
    input  logic             op0_valid_i,
    output logic             op0_ready_o,
    input  logic [FP_W-1:0]  op1_a_i,
    input  logic [FP_W-1:0]  op1_b_i,
    input  logic             op1_valid_i,
    output logic             op1_ready_o,
    output logic [FP_W-1:0]  mac_a_o,
    output logic [FP_W-1:0]  mac_b_o,
    output logic             mac_en_o,
    output logic             mac_clr_o,
    input  logic [FP_W-1:0]  mac_result_i,
    output logic             res_valid_o,
    output logic [FP_W-1:0]  res_data_o,
    output logic             res_id_o
);

    localparam int unsigned LAT_W = 4;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MAC_LAT);

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        ready_q, ready_d;
    logic              ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              issued_q, issued_d;
    logic              empty_q, empty_d;
    logic              clr_q, clr_d;
    logic              res_valid_q, res_valid_d;
    logic [FP_W-1:0]   res_data_q, res_data_d;
    logic              res_id_q, res_id_d;

    logic [1:0]        pick;
    logic [LEN_W-1:0]  len_sel;
    logic [LAT_W-1:0]  lat_dec;
    logic              gid;
    logic              accept;
    logic              skip;

    rr_arb2 u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    assign gid     = gnt_q[1];
    assign len_sel = pick[1] ? len1_i : len0_i;
    assign lat_dec = (lat_q == '0) ? '0 : lat_q - LAT_W'(1);

    // Operand path is a plain mux so a pair reaches the MAC in its accept cycle.
    assign mac_a_o = gid ? op1_a_i : op0_a_i;
    assign mac_b_o = gid ? op1_b_i : op0_b_i;
    assign accept  = gid ? (ready_q[1] & op1_valid_i) : (ready_q[0] & op0_valid_i);

`ifdef FP_MAC_ZERO_SKIP_EN
    assign skip = is_fp_zero(mac_a_o) | is_fp_zero(mac_b_o);
`else
    assign skip = 1'b0;
`endif

    assign mac_en_o    = accept & ~skip;
    assign mac_clr_o   = clr_q;
    assign gnt_o       = gnt_q;
    assign op0_ready_o = ready_q[0];
    assign op1_ready_o = ready_q[1];
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ready_q     <= '0;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            lat_q       <= '0;
            issued_q    <= 1'b0;
            empty_q     <= 1'b0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ready_q     <= ready_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            issued_q    <= issued_d;
            empty_q     <= empty_d;
            clr_q       <= clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ready_d     = 2'b00;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        issued_d    = issued_q;
        empty_d     = empty_q;
        clr_d       = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        unique case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d    = pick;
                    cnt_d    = len_sel;
                    empty_d  = (len_sel == '0);
                    issued_d = 1'b0;
                    lat_d    = '0;
                    if (len_sel == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLR;
                        clr_d   = 1'b1;
                    end
                end
            end
            CLR: begin
                state_d = RUN;
                ready_d = gnt_q;
            end
            RUN: begin
                ready_d = gnt_q;
                // lat_q tracks how much drain time is still owed to the latest mac_en.
                if (mac_en_o) begin
                    lat_d    = LAT_LOAD;
                    issued_d = 1'b1;
                end else begin
                    lat_d = lat_dec;
                end
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                        ready_d = 2'b00;
                        if (!issued_q && !mac_en_o) begin
                            lat_d = LAT_LOAD;
                        end
                    end
                end
            end
            DRAIN: begin
                lat_d = lat_dec;
                if (lat_q <= LAT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid_d = 1'b1;
                res_data_d  = empty_q ? '0 : mac_result_i;
                res_id_d    = gid;
                gnt_d       = 2'b00;
                ptr_d       = ~gid;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_mac_sched.sv
// Directed bench for fp_mac_sched with a stand-in MAC (XOR-accumulate, MAC_LAT=2).
module tb_fp_mac_sched;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAC_LAT = 2;
    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] FH = 32'h3F00_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [LEN_W-1:0] len0 = '0;
    logic [LEN_W-1:0] len1 = '0;
    logic [1:0]       gnt;
    logic [31:0]      op0_a = '0, op0_b = '0, op1_a = '0, op1_b = '0;
    logic             op0_valid = 1'b0, op1_valid = 1'b0;
    logic             op0_ready, op1_ready;
    logic [31:0]      mac_a, mac_b, mac_result;
    logic             mac_en, mac_clr;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_id;

    always #5 clk = ~clk;

    fp_mac_sched #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .len0_i       (len0),
        .len1_i       (len1),
        .gnt_o        (gnt),
        .op0_a_i      (op0_a),
        .op0_b_i      (op0_b),
        .op0_valid_i  (op0_valid),
        .op0_ready_o  (op0_ready),
        .op1_a_i      (op1_a),
        .op1_b_i      (op1_b),
        .op1_valid_i  (op1_valid),
        .op1_ready_o  (op1_ready),
        .mac_a_o      (mac_a),
        .mac_b_o      (mac_b),
        .mac_en_o     (mac_en),
        .mac_clr_o    (mac_clr),
        .mac_result_i (mac_result),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_id_o     (res_id)
    );

    // Stand-in MAC: a pulse at cycle c shows on mac_result at cycle c+2.
    logic        e1 = 1'b0;
    logic [31:0] v1 = '0;
    logic [31:0] acc = '0;
    assign mac_result = acc;
    always @(posedge clk) begin
        if (rst) begin
            e1  <= 1'b0;
            acc <= '0;
        end else begin
            e1 <= mac_en;
            v1 <= mac_a ^ mac_b;
            if (mac_clr) acc <= '0;
            else if (e1) acc <= acc + v1;
        end
    end

    // Monitor: event counters, timestamps and protocol invariants.
    int          cyc = 0;
    int          n_en = 0, n_clr = 0, n_res = 0, n_gnt = 0;
    int          clr_cyc = 0;
    int          en_cyc [512];
    logic [31:0] res_dat [32];
    logic        res_idv [32];
    int          res_cyc [32];
    logic [1:0]  gnt_prev = 2'b00;
    int          viol_gnt = 0, viol_both = 0, viol_rdy = 0, viol_en = 0, viol_mux = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_clr) begin
                n_clr   <= n_clr + 1;
                clr_cyc <= cyc;
            end
            if (mac_en) begin
                en_cyc[n_en[8:0]] <= cyc;
                n_en <= n_en + 1;
            end
            if (res_valid) begin
                res_dat[n_res[4:0]] <= res_data;
                res_idv[n_res[4:0]] <= res_id;
                res_cyc[n_res[4:0]] <= cyc;
                n_res <= n_res + 1;
            end
            if (gnt != 2'b00 && gnt_prev == 2'b00) n_gnt <= n_gnt + 1;
        end
        gnt_prev <= gnt;
        if (gnt == 2'b11) viol_gnt <= viol_gnt + 1;
        if (mac_en && mac_clr) viol_both <= viol_both + 1;
        if ((op0_ready && !gnt[0]) || (op1_ready && !gnt[1])) viol_rdy <= viol_rdy + 1;
        if (mac_en && !((op0_ready && op0_valid) || (op1_ready && op1_valid))) viol_en <= viol_en + 1;
        if (mac_en && ((gnt[1] ? op1_a : op0_a) != mac_a || (gnt[1] ? op1_b : op0_b) != mac_b))
            viol_mux <= viol_mux + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Operand sources, owned by the main process only.
    logic [31:0] a0 [16], b0 [16], a1 [16], b1 [16];
    int          i0 = 0, i1 = 0, n0 = 0, n1 = 0, ph0 = 0, ph1 = 0;
    logic [15:0] pat0 = '1, pat1 = '1;
    int          req_cyc = 0;

    task automatic load0(input logic [31:0] a, input logic [31:0] b, input int n);
        for (int k = 0; k < 16; k++) begin
            a0[k] = a;
            b0[k] = b;
        end
        i0 = 0; ph0 = 0; n0 = n; pat0 = '1;
    endtask

    task automatic load1(input logic [31:0] a, input logic [31:0] b, input int n);
        for (int k = 0; k < 16; k++) begin
            a1[k] = a;
            b1[k] = b;
        end
        i1 = 0; ph1 = 0; n1 = n; pat1 = '1;
    endtask

    // Streams both requesters until enough results/mac_en pulses or the cycle budget runs out.
    task automatic run(input int max_cyc, input int want_res, input int drop_gnt, input int want_en);
        int   k;
        int   r_s;
        int   e_s;
        int   g_s;
        logic t0, t1, r0, r1;
        k = 0; r_s = n_res; e_s = n_en; g_s = n_gnt;
        while (k < max_cyc) begin
            if (want_res > 0 && (n_res - r_s) >= want_res) break;
            if (want_en > 0 && (n_en - e_s) >= want_en) break;
            if (drop_gnt > 0 && (n_gnt - g_s) >= drop_gnt) begin
                req  = 2'b00;
                len0 = 8'h5A;
                len1 = 8'h5A;
            end
            op0_valid = (i0 < n0) && ((ph0 >= 16) ? 1'b1 : pat0[ph0[3:0]]);
            op1_valid = (i1 < n1) && ((ph1 >= 16) ? 1'b1 : pat1[ph1[3:0]]);
            op0_a = a0[i0[3:0]]; op0_b = b0[i0[3:0]];
            op1_a = a1[i1[3:0]]; op1_b = b1[i1[3:0]];
            @(negedge clk);
            t0 = op0_valid && op0_ready; r0 = op0_ready;
            t1 = op1_valid && op1_ready; r1 = op1_ready;
            @(posedge clk); #1;
            if (t0) i0++;
            if (r0) ph0++;
            if (t1) i1++;
            if (r1) ph1++;
            k++;
        end
        op0_valid = 1'b0;
        op1_valid = 1'b0;
    endtask

    task automatic start(input logic [1:0] r);
        req     = r;
        req_cyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r_b, e_b, c_b;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        op0_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_rdy0", 32'(op0_ready), 32'd0);
        check_eq("rst_rdy1", 32'(op1_ready), 32'd0);
        check_eq("rst_mac_en", 32'(mac_en), 32'd0);
        check_eq("rst_mac_clr", 32'(mac_clr), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", res_data, 32'd0);
        check_eq("rst_res_id", 32'(res_id), 32'd0);
        @(posedge clk); #1;
        op0_valid = 1'b0;

        // Single job, full rate, len 4.
        load0(F1, F2, 4); len0 = 8'd4;
        r_b = n_res; e_b = n_en; c_b = n_clr;
        start(2'b01);
        run(60, 1, 1, 0);
        check_eq("basic_res_cnt", 32'(n_res - r_b), 32'd1);
        check_eq("basic_data", res_dat[r_b], 32'hFE00_0000);
        check_eq("basic_id", 32'(res_idv[r_b]), 32'd0);
        check_eq("basic_latency", 32'(res_cyc[r_b] - req_cyc), 32'd9);
        check_eq("basic_clr_cnt", 32'(n_clr - c_b), 32'd1);
        check_eq("basic_clr_cyc", 32'(clr_cyc - req_cyc), 32'd1);
        check_eq("basic_en_cnt", 32'(n_en - e_b), 32'd4);
        check_eq("basic_en_first", 32'(en_cyc[e_b] - req_cyc), 32'd2);
        check_eq("basic_en_last", 32'(en_cyc[e_b + 3] - req_cyc), 32'd5);

        // Zero-length job from requester 1.
        load1(F3, F1, 0); len1 = 8'd0;
        r_b = n_res; e_b = n_en; c_b = n_clr;
        start(2'b10);
        run(20, 1, 1, 0);
        check_eq("zlen_res_cnt", 32'(n_res - r_b), 32'd1);
        check_eq("zlen_data", res_dat[r_b], 32'd0);
        check_eq("zlen_id", 32'(res_idv[r_b]), 32'd1);
        check_eq("zlen_latency", 32'(res_cyc[r_b] - req_cyc), 32'd2);
        check_eq("zlen_clr_cnt", 32'(n_clr - c_b), 32'd0);
        check_eq("zlen_en_cnt", 32'(n_en - e_b), 32'd0);

        // Both requesting continuously: four alternating jobs of two pairs.
        load0(F1, F2, 4); load1(F3, F1, 4);
        len0 = 8'd2; len1 = 8'd2;
        r_b = n_res;
        start(2'b11);
        run(200, 4, 4, 0);
        check_eq("alt_res_cnt", 32'(n_res - r_b), 32'd4);
        for (int j = 0; j < 4; j++) begin
            check_eq($sformatf("alt_id%0d", j), 32'(res_idv[r_b + j]), 32'(j % 2));
            check_eq($sformatf("alt_data%0d", j), res_dat[r_b + j],
                     (j % 2 == 0) ? 32'hFF00_0000 : 32'hFF80_0000);
        end

        // Stalling requester 0: valid pattern 1,0,0,1,0,1 during RUN.
        load0(F2, FH, 3); len0 = 8'd3; pat0 = 16'hFFE9;
        r_b = n_res; e_b = n_en;
        start(2'b01);
        run(60, 1, 1, 0);
        check_eq("stall_res_cnt", 32'(n_res - r_b), 32'd1);
        check_eq("stall_en_cnt", 32'(n_en - e_b), 32'd3);
        check_eq("stall_en0", 32'(en_cyc[e_b] - req_cyc), 32'd2);
        check_eq("stall_en1", 32'(en_cyc[e_b + 1] - req_cyc), 32'd5);
        check_eq("stall_en2", 32'(en_cyc[e_b + 2] - req_cyc), 32'd7);
        check_eq("stall_latency", 32'(res_cyc[r_b] - req_cyc), 32'd11);
        check_eq("stall_data", res_dat[r_b], 32'h7D00_0000);

        // Maximum length job runs all 255 pairs without wrap.
        load0(F1, F2, 255); len0 = 8'hFF;
        r_b = n_res; e_b = n_en;
        start(2'b01);
        run(400, 1, 1, 0);
        check_eq("max_res_cnt", 32'(n_res - r_b), 32'd1);
        check_eq("max_en_cnt", 32'(n_en - e_b), 32'd255);
        check_eq("max_latency", 32'(res_cyc[r_b] - req_cyc), 32'd260);
        check_eq("max_data", res_dat[r_b], 32'h0080_0000);

        // Reset in RUN after two of five pairs (cnt=3).
        load0(F1, F2, 5); len0 = 8'd5;
        r_b = n_res; e_b = n_en;
        start(2'b01);
        run(30, 0, 1, 2);
        check_eq("mid_en_before_rst", 32'(n_en - e_b), 32'd2);
        req = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        op0_valid = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
        check_eq("mid_rst_rdy0", 32'(op0_ready), 32'd0);
        check_eq("mid_rst_mac_en", 32'(mac_en), 32'd0);
        @(posedge clk); #1;
        op0_valid = 1'b0;
        c_b = n_clr;
        repeat (15) @(posedge clk);
        #1;
        check_eq("mid_no_result", 32'(n_res - r_b), 32'd0);
        check_eq("mid_no_clr", 32'(n_clr - c_b), 32'd0);
        load0(F1, F2, 1); len0 = 8'd1;
        start(2'b01);
        run(30, 1, 1, 0);
        check_eq("post_rst_res_cnt", 32'(n_res - r_b), 32'd1);
        check_eq("post_rst_data", res_dat[r_b], 32'h7F80_0000);
        check_eq("post_rst_id", 32'(res_idv[r_b]), 32'd0);
        check_eq("post_rst_latency", 32'(res_cyc[r_b] - req_cyc), 32'd6);

`ifdef FP_MAC_ZERO_SKIP_EN
        // Signed zeros are consumed without a MAC strobe.
        load0(F1, F1, 3); len0 = 8'd3;
        a0[0] = 32'h0000_0000; b0[0] = F2;
        a0[1] = 32'h8000_0000; b0[1] = F1;
        r_b = n_res; e_b = n_en;
        start(2'b01);
        run(40, 1, 1, 0);
        check_eq("skip_res_cnt", 32'(n_res - r_b), 32'd1);
        check_eq("skip_en_cnt", 32'(n_en - e_b), 32'd1);
        check_eq("skip_en_cyc", 32'(en_cyc[e_b] - req_cyc), 32'd4);
        check_eq("skip_latency", 32'(res_cyc[r_b] - req_cyc), 32'd8);
        check_eq("skip_data", res_dat[r_b], 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check_eq("inv_gnt_onehot", 32'(viol_gnt), 32'd0);
        check_eq("inv_en_clr_excl", 32'(viol_both), 32'd0);
        check_eq("inv_ready_gnt", 32'(viol_rdy), 32'd0);
        check_eq("inv_en_on_accept", 32'(viol_en), 32'd0);
        check_eq("inv_operand_mux", 32'(viol_mux), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mac_sched.md
Name: fp_mac_sched

Overview:
Scheduler that shares one single-precision floating-point MAC datapath between two requesters, one dot-product job at a time.
- Each requester posts a job length, then streams operand pairs over a valid/ready handshake.
- The block arbitrates round-robin between requesters, clears the accumulator, and issues one MAC enable per accepted pair.
- After the pipeline drains, it returns the 32-bit result tagged with the requester id.

Parameters:
LEN_W, 8, width of job length (max LEN_W-bit count of pairs per job)
MAC_LAT, 2, cycles from a mac_en pulse to its contribution being visible on mac_result (range 1..15)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous active-high reset
req  in  2  per-requester job request, level
len0  in  LEN_W  job length of requester 0, sampled at grant
len1  in  LEN_W  job length of requester 1, sampled at grant
gnt  out  2  one-hot grant, held for whole job
op0_a, op0_b  in  32  requester 0 operand pair (IEEE-754 single)
op0_valid  in  1  requester 0 pair valid
op0_ready  out  1  requester 0 pair accepted when valid&ready
op1_a, op1_b  in  32  requester 1 operand pair
op1_valid  in  1  requester 1 pair valid
op1_ready  out  1  requester 1 pair accepted when valid&ready
mac_a, mac_b  out  32  operands to MAC, muxed from granted requester
mac_en  out  1  MAC accumulate strobe, one per issued pair
mac_clr  out  1  accumulator clear, one-cycle pulse
mac_result  in  32  MAC accumulator value
res_valid  out  1  one-cycle result strobe
res_data  out  32  dot-product result
res_id  out  1  requester owning res_data

Behaviour:
Reset values:
- state=IDLE; gnt=0; op*_ready=0; mac_en=0; mac_clr=0; res_valid=0; res_data=0; res_id=0; rr pointer=0 (requester 0 preferred).
- rst mid-job aborts the job immediately: no result, no clear pulse, requesters must re-request.

States:
- IDLE: if req!=0, pick a requester. If only one is requesting, pick it. If both, pick the pointer side. Set gnt one-hot next cycle, latch cnt<=len of the winner, then go to CLR. If the latched length is 0, go to DONE with res_data=0 and skip CLR/RUN/DRAIN.
- CLR: mac_clr=1 for exactly one cycle; no operands accepted; go to RUN.
- RUN: granted op*_ready=1; the other requester's ready=0.
  - On accept: mac_en=1 in the same cycle; mac_a/mac_b combinationally equal the granted op*_a/op*_b; cnt decrements.
  - Accepting the pair that brings cnt to 0 goes to DRAIN; ready drops in DRAIN.
  - valid low stalls indefinitely; no timeout.
- DRAIN: wait exactly MAC_LAT cycles after the last mac_en, then go to DONE.
- DONE: res_valid=1 for one cycle; res_data=mac_result sampled this cycle; res_id=granted index.
  - gnt cleared and pointer set to the non-granted requester, both registered so they take effect the following cycle.
  - Return to IDLE. Re-arbitration occurs no earlier than the cycle after DONE.
mac_en and mac_clr are never asserted in the same cycle. mac_en is asserted only in RUN.
Job latency for L pairs streamed at full rate: 1 (grant) + 1 (CLR) + L + MAC_LAT + 1 (DONE) cycles from req to res_valid.
Boundary rules:
- req deasserting while granted is ignored; the job completes.
- A new req from the granted side during DONE is not served until IDLE.
- len inputs are ignored except in the grant cycle.
- The count is unsigned LEN_W bits. len=2^LEN_W-1 is legal and runs the full count without wrap.

Optional Feature:
FP_MAC_ZERO_SKIP_EN
- Defined: an accepted pair where either operand has exponent==0 and mantissa==0 (±0) is consumed and cnt decrements, but mac_en stays 0 (power saving). DRAIN still waits MAC_LAT after the last actual mac_en. If no pair was issued, DRAIN waits MAC_LAT from entry.
- Undefined: every accepted pair asserts mac_en.

Decomposition:
Package fp_mac_pkg:
- state enum {IDLE, CLR, RUN, DRAIN, DONE}
- FP_W=32, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22
- function is_fp_zero(32-bit)
Sub-module rr_arb2: combinational 2-way round-robin pick from req and pointer, outputs one-hot winner; the pointer register stays in fp_mac_sched.

Test Plan:
- Reset during RUN with req0 granted, cnt=3: gnt=0, ready=0, mac_en=0 next cycle; no res_valid until a new job completes.
- req0 alone, len0=4, pairs (1.0,2.0)x4 at full rate, MAC_LAT=2: one mac_clr pulse, four consecutive mac_en, res_valid exactly 9 cycles after req rises, res_data=mac_result, res_id=0.
- req=2'b11 continuously, len0=len1=2: jobs alternate 0,1,0,1; gnt is never both bits high; op1_ready=0 throughout requester 0's jobs.
- len1=0 with req1 alone: no mac_clr, no mac_en; res_valid with res_data=0, res_id=1 two cycles after req.
- Stall: len0=3, op0_valid toggles 1,0,0,1,0,1: mac_en count = 3, asserted only on accept cycles; DRAIN waits 2 cycles after the third.
- With FP_MAC_ZERO_SKIP_EN: len0=3, pairs (0x00000000,x), (0x80000000,x), (1.0,1.0): one mac_en only; cnt reaches 0; result returned normally.
